// File: rtl/lieat_imem_axi_rd_slave_pkg.sv
// Shared encodings and widths for the instruction-fetch AXI read responder.
// Also used by the icache side so both agree on line and word widths.
package lieat_imem_axi_rd_slave_pkg;

    localparam int XLEN_C   = 32;
    localparam int LINE_W_C = 2 * XLEN_C;
    localparam int CNT_W    = 4;

    typedef enum logic [3:0] {
        ST_IDLE = 4'b0001,
        ST_WAIT = 4'b0010,
        ST_READ = 4'b0100,
        ST_RESP = 4'b1000
    } head_state_e;

endpackage

// File: rtl/lieat_general_dff.sv
// Generic D flop bank with asynchronous active-high reset to a parameter value.
// Latency: one cycle. Backpressure: none.
module lieat_general_dff #(
    parameter int             W       = 1,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q <= RST_VAL;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/lieat_general_sync_fifo.sv
// Generic synchronous FIFO, DEPTH a power of two; head is visible combinationally.
// Latency: pushed data is at the head one cycle later. Backpressure: push ignored when full.
module lieat_general_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign head_dat = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

endmodule

// File: rtl/lieat_imem_axi_rd_slave.sv
// In-order AXI read responder for instruction fetch, backed by a preloadable line RAM.
// Latency: LATENCY cycles from an idle AR handshake; LATENCY+1 cycles between back-to-back beats.
// Backpressure: arready drops when the request queue is full; R beat held until rready.
module lieat_imem_axi_rd_slave
    import lieat_imem_axi_rd_slave_pkg::*;
#(
    parameter int XLEN    = XLEN_C,
    parameter int MEM_AW  = 10,
    parameter int LATENCY = 2,
    parameter int QDEPTH  = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [XLEN-1:0]     axi_araddr,
    input  logic                axi_arvalid,
    output logic                axi_arready,
    output logic [2*XLEN-1:0]   axi_rdata,
    output logic                axi_rvalid,
    input  logic                axi_rready,
    input  logic                init_wen,
    input  logic [MEM_AW-1:0]   init_addr,
    input  logic [2*XLEN-1:0]   init_wdata
);

    localparam int LINE_W = 2 * XLEN;

    head_state_e       state_q;
    head_state_e       state_d;
    logic [3:0]        state_bits;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [XLEN-1:0]   head_addr;
    logic              q_full;
    logic              q_empty;
    logic              q_pop;
    logic              ar_hs;
    logic              r_hs;
    logic              more_work;
    logic              ram_ren;
    logic [MEM_AW-1:0] ram_raddr;
    logic [LINE_W-1:0] ram [2**MEM_AW];
    logic [LINE_W-1:0] ram_q;
    logic [LINE_W-1:0] line_swapped;
    logic              unused_addr_bits;

    assign axi_arready = ~q_full;
    assign ar_hs       = axi_arvalid & axi_arready;
    assign r_hs        = axi_rvalid & axi_rready;
    assign more_work   = ~q_empty | ar_hs;

    lieat_general_sync_fifo #(
        .WIDTH (XLEN),
        .DEPTH (QDEPTH)
    ) u_req_q (
        .clock    (clock),
        .reset    (reset),
        .push     (ar_hs),
        .push_dat (axi_araddr),
        .pop      (q_pop),
        .head_dat (head_addr),
        .full     (q_full),
        .empty    (q_empty)
    );

    lieat_general_dff #(
        .W       (4),
        .RST_VAL (ST_IDLE)
    ) u_state_ff (
        .clock (clock),
        .reset (reset),
        .d     (state_d),
        .q     (state_bits)
    );
    assign state_q = head_state_e'(state_bits);

    lieat_general_dff #(
        .W       (CNT_W),
        .RST_VAL ('0)
    ) u_cnt_ff (
        .clock (clock),
        .reset (reset),
        .d     (cnt_d),
        .q     (cnt_q)
    );

    // The push cycle out of IDLE already counts as the first wait cycle, which is
    // why the idle path loads one less than the back-to-back path.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (ar_hs) begin
                    if (LATENCY == 2) begin
                        state_d = ST_READ;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_W'(LATENCY - 3);
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_READ;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_READ: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (r_hs) begin
                    if (more_work) begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_W'(LATENCY - 2);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // With the minimum latency the RAM read leaves straight from the incoming address.
    always_comb begin
        q_pop     = 1'b0;
        ram_ren   = 1'b0;
        ram_raddr = head_addr[MEM_AW+2:3];
        unique case (state_q)
            ST_IDLE: begin
                if ((LATENCY == 2) && ar_hs) begin
                    ram_ren   = 1'b1;
                    ram_raddr = axi_araddr[MEM_AW+2:3];
                end
            end
            ST_WAIT: begin
                ram_ren = (cnt_q == '0);
            end
            ST_READ: begin
                q_pop = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Preload write and read share a cycle without forwarding: the read sees old data.
    always_ff @(posedge clock) begin
        if (init_wen) begin
            ram[init_addr] <= init_wdata;
        end
        if (ram_ren) begin
            ram_q <= ram[ram_raddr];
        end
    end

    assign line_swapped = head_addr[2] ? {ram_q[XLEN-1:0], ram_q[LINE_W-1:XLEN]} : ram_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            axi_rvalid <= 1'b0;
            axi_rdata  <= '0;
        end else if (state_q == ST_READ) begin
            axi_rvalid <= 1'b1;
            axi_rdata  <= line_swapped;
        end else if (r_hs) begin
            axi_rvalid <= 1'b0;
        end
    end

    assign unused_addr_bits = ^{axi_araddr[XLEN-1:MEM_AW+3], axi_araddr[2:0],
                                head_addr[XLEN-1:MEM_AW+3], head_addr[1:0]};

endmodule
